bram_reinit_arb: RTL
====================

# bram_reinit_arb

Write-port controller for the 18-bit x 4096 block-RAM memory instance. Shares the memory's single write port between a user requester and a reinit sweep engine that rewrites every word, in ascending address order, from a valid/ready init stream. Reads pass straight through to the memory. Sits between the user logic, the bitstream-reinit data source and the memory wrapper, which has a write enable.

## Interface
- `WID_MEM`, 18, data width of one memory word
- `DEPTH_MEM`, 4096, number of words; must be a power of two
- `ADDR_W`, 12, address width; equals $clog2(DEPTH_MEM)

- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  synchronous, active-low reset
- `user_we`  in  1  user write request
- `user_waddr`  in  ADDR_W  user write address
- `user_din`  in  WID_MEM  user write data
- `user_wready`  out  1  user write accepted this cycle when high with `user_we`
- `user_raddr`  in  ADDR_W  user read address
- `user_dout`  out  WID_MEM  user read data
- `reinit_start`  in  1  single-cycle pulse that starts a sweep
- `reinit_abort`  in  1  single-cycle pulse that cancels a sweep
- `init_data`  in  WID_MEM  init stream word
- `init_valid`  in  1  init stream valid
- `init_ready`  out  1  init stream ready
- `reinit_busy`  out  1  high whenever the state is not IDLE
- `reinit_done`  out  1  one-cycle pulse when a sweep completes
- `reinit_cksum`  out  WID_MEM  XOR checksum of the last sweep
- `mem_we`, `mem_waddr`, `mem_din`  out  1 / ADDR_W / WID_MEM  memory write port, all registered
- `mem_raddr`  out  ADDR_W  memory read address; combinationally equal to `user_raddr`
- `mem_dout`  in  WID_MEM  memory read data; forwarded combinationally to `user_dout`

## Operation
- The FSM has three states: IDLE, SWEEP and DONE.
- **IDLE**
  - `user_wready`=1.
  - A user beat is `user_we`. It registers `mem_we`=1, `mem_waddr`=`user_waddr` and `mem_din`=`user_din`.
  - `reinit_start` clears the address counter and the checksum, then moves to SWEEP.
  - If `reinit_start` and `user_we` are high in the same cycle, the user write is accepted and the sweep starts.
- **SWEEP**
  - `user_wready`=0 and `init_ready`=1.
  - A beat is `init_valid`&&`init_ready`. It registers the write of `init_data` at the counter address, then increments the counter.
  - Gaps in `init_valid` do not skip addresses.
  - Address DEPTH_MEM-1 is the final beat. After it the FSM moves to DONE; the counter does not wrap.
  - `reinit_abort` moves to IDLE and `reinit_done` is not asserted. A beat in the abort cycle is still written.
  - If `reinit_abort` coincides with the final beat, completion wins and the FSM goes to DONE.
  - `reinit_start` is ignored.
- **DONE**
  - Lasts one cycle, with `reinit_done`=1 and `user_wready`=0. Then moves to IDLE.
- `mem_we`=0 in every cycle with no beat.
- User reads are never stalled, including during SWEEP. During a sweep the read data is whatever the memory holds at that moment.
- Reset values:
  - state IDLE, counter 0.
  - `mem_we`=0, `mem_waddr`=0, `mem_din`=0.
  - `init_ready`=0, `reinit_busy`=0, `reinit_done`=0, `reinit_cksum`=0.
  - `user_wready`=1 in the cycle after reset deasserts; it is 0 while `reset` is low.
- Reset asserted mid-sweep abandons the sweep: no done pulse and no further writes.

## Timing
- Write latency is one cycle: a beat accepted in cycle N gives `mem_we`=1 in cycle N+1. The memory updates at the end of N+1.
- Read latency is the memory's one cycle. The controller adds no latency on the read path.
- With `init_valid` held high and `reinit_start` in cycle 0:
  - SWEEP covers cycles 1..4096; beat k is in cycle k+1.
  - DONE and `reinit_done` are in cycle 4097.
  - The last `mem_we` is in cycle 4097.
  - `reinit_busy` is high in cycles 1..4097.
- `init_ready` depends only on state, never on `init_valid`.

## Configuration
- The macro `BRAM_REINIT_CKSUM_EN` controls the checksum.
- **Defined:**
  - `reinit_cksum` accumulates the XOR of every sweep beat's data.
  - It is cleared on `reinit_start`.
  - It is valid from the `reinit_done` cycle and held until the next start.
- **Undefined:**
  - No accumulator is built.
  - `reinit_cksum` is tied to 0.

## Structure
- Package `bram_ctrl_pkg` holds:
  - the `reinit_state_t` enum (IDLE, SWEEP, DONE);
  - the default `WID_MEM`, `DEPTH_MEM` and `ADDR_W` constants.
- One natural sub-module: `bram_reinit_cksum`, the XOR accumulator with clear and enable, instantiated only under the macro.
- The FSM, counter and write mux stay in the top.

## Test plan
- After reset: `user_we`=1, `user_waddr`=0x005, `user_din`=0x3FFFF.
  - Next cycle: `mem_we`=1, `mem_waddr`=0x005, `mem_din`=0x3FFFF.
  - Then `user_raddr`=0x005 returns 0x3FFFF one cycle later.
- Start pulse with `init_valid` held high and data = address:
  - 4096 writes to addresses 0..0xFFF.
  - `reinit_done` only in cycle 4097.
  - Readback of 0x800 returns 0x00800.
- `user_we` held high across a sweep:
  - `user_wready`=0 through DONE, with no user write in that window.
  - The user write is issued in the first IDLE cycle.
- `init_valid` toggling 1,0,0,1:
  - `mem_waddr` increments only on beats.
  - No address is skipped or duplicated.
- `reinit_abort` on beat 100:
  - Addresses 0..100 are written.
  - `reinit_busy`=0 next cycle, with no `reinit_done`.
- With `BRAM_REINIT_CKSUM_EN`: a sweep with data = address gives `reinit_cksum`=0x00000. All words 0x00001 gives 0x00000. Words 0x00001 at even addresses and 0 at odd give 0x00000. Word 0x3FFFF at address 0 and 0 elsewhere gives 0x3FFFF.

Source files
------------

// File: rtl/bram_ctrl_pkg.sv
// Shared types and default geometry for the block-RAM write-port controller.
package bram_ctrl_pkg;

  localparam int WID_MEM_DFLT   = 18;
  localparam int DEPTH_MEM_DFLT = 4096;
  localparam int ADDR_W_DFLT    = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } reinit_state_t;

endpackage

// File: rtl/bram_reinit_cksum.sv
// XOR accumulator over reinit sweep data; clear has priority over enable.
module bram_reinit_cksum
  import bram_ctrl_pkg::*;
#(
  parameter int WID = WID_MEM_DFLT
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clr,
  input  logic           en,
  input  logic [WID-1:0] din,
  output logic [WID-1:0] cksum
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      cksum <= '0;
    end else if (clr) begin
      cksum <= '0;
    end else if (en) begin
      cksum <= cksum ^ din;
    end
  end

endmodule

// File: rtl/bram_reinit_arb.sv
// Write-port arbiter between user writes and an ascending reinit sweep.
// Define BRAM_REINIT_CKSUM_EN to build the XOR checksum of each sweep.
module bram_reinit_arb
  import bram_ctrl_pkg::*;
#(
  parameter int WID_MEM   = WID_MEM_DFLT,
  parameter int DEPTH_MEM = DEPTH_MEM_DFLT,
  parameter int ADDR_W    = ADDR_W_DFLT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               user_we,
  input  logic [ADDR_W-1:0]  user_waddr,
  input  logic [WID_MEM-1:0] user_din,
  output logic               user_wready,
  input  logic [ADDR_W-1:0]  user_raddr,
  output logic [WID_MEM-1:0] user_dout,
  input  logic               reinit_start,
  input  logic               reinit_abort,
  input  logic [WID_MEM-1:0] init_data,
  input  logic               init_valid,
  output logic               init_ready,
  output logic               reinit_busy,
  output logic               reinit_done,
  output logic [WID_MEM-1:0] reinit_cksum,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_waddr,
  output logic [WID_MEM-1:0] mem_din,
  output logic [ADDR_W-1:0]  mem_raddr,
  input  logic [WID_MEM-1:0] mem_dout
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH_MEM - 1);

  reinit_state_t     state, state_next;
  logic [ADDR_W-1:0] cnt;
  logic              user_beat;
  logic              init_beat;
  logic              start_go;
  logic              last_beat;

  // Read path is pure pass-through; the memory supplies the one-cycle latency.
  assign mem_raddr = user_raddr;
  assign user_dout = mem_dout;

  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    state_next  = state;
    user_wready = 1'b0;
    init_ready  = 1'b0;
    reinit_busy = 1'b1;
    reinit_done = 1'b0;
    user_beat   = 1'b0;
    init_beat   = 1'b0;
    start_go    = 1'b0;
    last_beat   = 1'b0;
    case (state)
      IDLE: begin
        reinit_busy = 1'b0;
        user_wready = reset;
        user_beat   = user_we;
        start_go    = reinit_start;
        if (reinit_start) state_next = SWEEP;
      end
      SWEEP: begin
        init_ready = 1'b1;
        init_beat  = init_valid;
        last_beat  = init_valid && (cnt == LAST_ADDR);
        // Completion beats abort when both land on the final word.
        if (last_beat)         state_next = DONE;
        else if (reinit_abort) state_next = IDLE;
      end
      DONE: begin
        reinit_done = 1'b1;
        state_next  = IDLE;
      end
      default: begin
        reinit_busy = 1'b0;
        state_next  = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values together.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Counter holds at the last address instead of wrapping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (start_go) begin
      cnt <= '0;
    end else if (init_beat && !last_beat) begin
      cnt <= cnt + 1'b1;
    end
  end

  // NOTE: only the write-port registers are reset; the storage array in the wrapper is not.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_din   <= '0;
    end else if (user_beat) begin
      mem_we    <= 1'b1;
      mem_waddr <= user_waddr;
      mem_din   <= user_din;
    end else if (init_beat) begin
      mem_we    <= 1'b1;
      mem_waddr <= cnt;
      mem_din   <= init_data;
    end else begin
      mem_we    <= 1'b0;
    end
  end

`ifdef BRAM_REINIT_CKSUM_EN
  bram_reinit_cksum #(
    .WID (WID_MEM)
  ) u_cksum (
    .clk   (clk),
    .reset (reset),
    .clr   (start_go),
    .en    (init_beat),
    .din   (init_data),
    .cksum (reinit_cksum)
  );
`else
  assign reinit_cksum = '0;
`endif

endmodule
